cpu_thermal_monitor: RTL
========================

# cpu_thermal_monitor

Qualifies raw CPU temperature samples into a clean, debounced `cpu_overheated` flag. It sits directly upstream of the computer shut-off logic, which consumes `cpu_overheated`. The block applies hysteresis and consecutive-sample debounce, and includes a sensor-timeout watchdog that fails safe to "overheated". It also counts overheat events for status reporting.

## Interface
- `TEMP_W`, 8: temperature sample width in bits, unsigned °C.
- `HOT_THRESH`, 85: a sample is hot when `temp >= HOT_THRESH`.
- `COOL_THRESH`, 75: a sample is cool when `temp <= COOL_THRESH`. Must be < `HOT_THRESH`.
- `DEBOUNCE`, 4: number of consecutive qualifying samples needed to change state. Must be ≥ 1.
- `TIMEOUT`, 1000: consecutive cycles with no `temp_valid` before a sensor fault. Must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `temp_valid` in 1: qualifies `temp` for one cycle.
- `temp` in `TEMP_W`: temperature sample.
- `cpu_overheated` out 1: registered overheat flag, fed to the shut-off stage.
- `sensor_fault` out 1: registered; high while the watchdog has expired.
- `event_count` out 8: saturating count of NORMAL→OVERHEATED transitions.

## Operation
- States: NORMAL, OVERHEATED, FAULT.
- Internal counters:
  - `hot_cnt` and `cool_cnt` are `$clog2(DEBOUNCE+1)` bits wide.
  - `idle_cnt` is `$clog2(TIMEOUT+1)` bits wide.
- The NORMAL/OVERHEATED debounce counters change only on cycles with `temp_valid`=1.
- NORMAL:
  - A hot sample increments `hot_cnt`; any non-hot sample clears it.
  - When a hot sample brings `hot_cnt` to `DEBOUNCE`, go to OVERHEATED, clear `hot_cnt`, and increment `event_count` (saturating at 255).
- OVERHEATED:
  - A cool sample increments `cool_cnt`; any sample > `COOL_THRESH` clears it.
  - When a cool sample brings `cool_cnt` to `DEBOUNCE`, go to NORMAL and clear `cool_cnt`.
  - Samples between `COOL_THRESH` and `HOT_THRESH` never satisfy either debounce (hysteresis band).
- Watchdog:
  - `idle_cnt` clears on every `temp_valid` cycle and otherwise increments, saturating at `TIMEOUT`.
  - When it reaches `TIMEOUT` from NORMAL or OVERHEATED, go to FAULT and clear `hot_cnt` and `cool_cnt`.
  - `temp_valid`=1 on the cycle the count would reach `TIMEOUT` takes priority: no fault.
- FAULT:
  - `cpu_overheated`=1 and `sensor_fault`=1.
  - The first valid sample moves to OVERHEATED with `cool_cnt`=0; that sample is not counted toward cooling.
  - Leaving FAULT does not increment `event_count`.
- Output decode: `cpu_overheated` = (state is OVERHEATED or FAULT); `sensor_fault` = (state is FAULT). Both are registered with the state.
- Reset mid-operation: the next edge forces NORMAL and clears every counter and output regardless of inputs.

## Timing
- Reset values: `cpu_overheated`=0, `sensor_fault`=0, `event_count`=0, state NORMAL.
- Assert latency: `cpu_overheated` rises on the same edge that samples the `DEBOUNCE`-th consecutive hot sample.
- Deassert latency: `cpu_overheated` falls on the edge that samples the `DEBOUNCE`-th consecutive cool sample.
- Non-consecutive valid samples still count as consecutive; only the values of valid samples matter, not the gaps between them.
- Fault latency: `sensor_fault` rises on the `TIMEOUT`-th consecutive edge with `temp_valid`=0. It falls on the edge that samples the next valid sample.
- `DEBOUNCE`=1: a single qualifying sample switches state on that edge.

## Configuration
- `THERMAL_PEAK_EN` defined:
  - Adds input `peak_clr` (1 bit) and output `peak_temp` (`TEMP_W` bits, reset 0).
  - `peak_temp` holds the maximum valid `temp` seen since reset or since the last `peak_clr`.
  - With `peak_clr` and `temp_valid` in the same cycle, `peak_temp` loads `temp`. With `peak_clr` alone, it loads 0.
  - `peak_temp` updates on the edge that samples the value.
- Not defined: `peak_clr` and `peak_temp` ports and their register are absent. All other behaviour is identical.

## Test plan
- Reset, then 4 valid samples of 90 → `cpu_overheated` rises on the 4th sampling edge and `event_count`=1.
- Samples 90, 90, 90, 80, 90, 90, 90 → `cpu_overheated` stays 0; the 80 sample cleared `hot_cnt`.
- From OVERHEATED, samples 70, 70, 80, 70, 70, 70, 70 → `cpu_overheated` falls only on the final 70.
- From NORMAL, no `temp_valid` for 1000 cycles → `sensor_fault`=1 and `cpu_overheated`=1 on the 1000th edge.
  - Then one sample of 60 → `sensor_fault`=0 and `cpu_overheated` stays 1 (OVERHEATED).
  - Then 4 more samples of 60 → NORMAL.
- 256 hot/cool cycles → `event_count` saturates at 255. Assert `reset` mid-debounce (after 2 hot samples), then 2 more hot samples → `cpu_overheated`=0.
- With `THERMAL_PEAK_EN`: samples 50, 92, 70 → `peak_temp`=92. Then `peak_clr` together with a valid 66 → `peak_temp`=66.

Source files
------------

// File: rtl/cpu_thermal_monitor.sv
// ----------------------------------------------------------------------------
// cpu_thermal_monitor
//
// Turns raw CPU temperature samples into a clean, debounced overheat flag for
// the shut-off stage. The flag is set after DEBOUNCE consecutive hot samples
// and cleared after DEBOUNCE consecutive cool samples. Samples that are
// neither hot nor cool fall in the hysteresis band and count toward neither.
// A watchdog forces a fail-safe FAULT state (flag held high) if no valid
// sample arrives for TIMEOUT cycles. NORMAL->OVERHEATED transitions are
// counted in a saturating 8-bit counter.
//
// Optional feature macro: THERMAL_PEAK_EN
//   When defined, the block gains a peak-temperature tracker, with a
//   peak_clr input and a peak_temp output.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous, active-high
//   temp_valid     in   qualifies temp for one cycle
//   temp           in   [TEMP_W-1:0] temperature sample, unsigned degC
//   peak_clr       in   (THERMAL_PEAK_EN only) clears/reloads peak_temp
//   peak_temp      out  (THERMAL_PEAK_EN only) max valid temp since clear
//   cpu_overheated out  registered; high in OVERHEATED or FAULT
//   sensor_fault   out  registered; high in FAULT
//   event_count    out  [7:0] saturating count of NORMAL->OVERHEATED events
// ----------------------------------------------------------------------------
module cpu_thermal_monitor #(
    parameter int TEMP_W      = 8,
    parameter int HOT_THRESH  = 85,
    parameter int COOL_THRESH = 75,
    parameter int DEBOUNCE    = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp,
`ifdef THERMAL_PEAK_EN
    input  logic              peak_clr,
    output logic [TEMP_W-1:0] peak_temp,
`endif
    output logic              cpu_overheated,
    output logic              sensor_fault,
    output logic [7:0]        event_count
);

    localparam int CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    // Thresholds and terminal counts at the width of the values they are
    // compared against, so every comparison is width-matched.
    localparam logic [TEMP_W-1:0] HOT_T     = TEMP_W'(HOT_THRESH);
    localparam logic [TEMP_W-1:0] COOL_T    = TEMP_W'(COOL_THRESH);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        OVERHEATED = 2'd1,
        FAULT      = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    hot_cnt;
    logic [CNT_W-1:0]    cool_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic is_hot;
    logic is_cool;
    logic timeout_now;

    assign is_hot  = (temp >= HOT_T);
    assign is_cool = (temp <= COOL_T);

    // The watchdog trips on the edge where the idle count would reach
    // TIMEOUT. A valid sample on that same cycle wins, so it is excluded.
    assign timeout_now = !temp_valid && (idle_cnt == IDLE_LAST);

    // NOTE: every register here is sequential state, so all assignments in
    // always_ff are non-blocking; blocking ones would race with readers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= NORMAL;
            hot_cnt        <= '0;
            cool_cnt       <= '0;
            idle_cnt       <= '0;
            cpu_overheated <= 1'b0;
            sensor_fault   <= 1'b0;
            event_count    <= '0;
        end else begin
            // Watchdog counter: cleared by any valid sample, else saturating.
            if (temp_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // Outputs are assigned alongside each state change so they are
            // registered together with the state and never lag it.
            unique case (state)
                NORMAL: begin
                    if (timeout_now) begin
                        state          <= FAULT;
                        hot_cnt        <= '0;
                        cool_cnt       <= '0;
                        cpu_overheated <= 1'b1;
                        sensor_fault   <= 1'b1;
                    end else if (temp_valid) begin
                        if (!is_hot) begin
                            hot_cnt <= '0;
                        end else if (hot_cnt == DEB_LAST) begin
                            state          <= OVERHEATED;
                            hot_cnt        <= '0;
                            cool_cnt       <= '0;
                            cpu_overheated <= 1'b1;
                            sensor_fault   <= 1'b0;
                            if (event_count != 8'hFF) begin
                                event_count <= event_count + 8'd1;
                            end
                        end else begin
                            hot_cnt <= hot_cnt + 1'b1;
                        end
                    end
                end

                OVERHEATED: begin
                    if (timeout_now) begin
                        state          <= FAULT;
                        hot_cnt        <= '0;
                        cool_cnt       <= '0;
                        cpu_overheated <= 1'b1;
                        sensor_fault   <= 1'b1;
                    end else if (temp_valid) begin
                        if (!is_cool) begin
                            cool_cnt <= '0;
                        end else if (cool_cnt == DEB_LAST) begin
                            state          <= NORMAL;
                            cool_cnt       <= '0;
                            hot_cnt        <= '0;
                            cpu_overheated <= 1'b0;
                            sensor_fault   <= 1'b0;
                        end else begin
                            cool_cnt <= cool_cnt + 1'b1;
                        end
                    end
                end

                FAULT: begin
                    // The recovering sample only proves the sensor is alive;
                    // it is deliberately not counted toward cooling.
                    if (temp_valid) begin
                        state          <= OVERHEATED;
                        cool_cnt       <= '0;
                        hot_cnt        <= '0;
                        cpu_overheated <= 1'b1;
                        sensor_fault   <= 1'b0;
                    end
                end

                default: begin
                    state          <= NORMAL;
                    hot_cnt        <= '0;
                    cool_cnt       <= '0;
                    cpu_overheated <= 1'b0;
                    sensor_fault   <= 1'b0;
                end
            endcase
        end
    end

`ifdef THERMAL_PEAK_EN
    // Clear has priority; a sample arriving with the clear becomes the new
    // peak so that it is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_temp <= '0;
        end else if (peak_clr) begin
            peak_temp <= temp_valid ? temp : '0;
        end else if (temp_valid && (temp > peak_temp)) begin
            peak_temp <= temp;
        end
    end
`endif

endmodule
